adu_assembler: RTL
==================

# adu_assembler

Byte-to-address assembly unit: the receive-side counterpart of the address data unit that drives a 16-bit address onto the 8-bit bus one byte at a time. It collects two consecutive bytes from the 8-bit data bus, assembles them into a 16-bit address, and presents that address with a valid/ack handshake to the CPU datapath, for example the PC load path or the memory address register. A per-byte timeout aborts a stalled transfer. A post-increment input supports sequential addressing.

## Interface

Parameters:
- LO_FIRST, 1, byte order: 1 = low byte arrives first (little-endian); 0 = high byte first.
- TIMEOUT, 16, maximum cycles to wait for each byte, range 0..255; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- d  in  8  data bus byte.
- start  in  1  request a new two-byte capture.
- dv  in  1  byte on d is valid this cycle.
- ack  in  1  consumer has taken a.
- inc  in  1  increment the held address by one.
- a  out  16  assembled address (registered).
- valid  out  1  a holds a freshly assembled address awaiting ack.
- busy  out  1  capture in progress (FIRST or SECOND state).
- err  out  1  one-cycle pulse: capture aborted by timeout.

## Operation

- State machine has four states: IDLE, FIRST, SECOND, HOLD.
- A private 16-bit shadow register (tmp) collects bytes. Output a changes only when a capture completes, on inc, or on reset.
- IDLE:
  - busy=0, valid=0.
  - start=1 -> FIRST; timeout counter cleared.
- FIRST:
  - busy=1.
  - dv=1 -> d is written to tmp[7:0] (LO_FIRST=1) or tmp[15:8] (LO_FIRST=0); counter cleared; -> SECOND.
  - dv=0 -> counter increments.
- SECOND:
  - busy=1.
  - dv=1 -> the other half of the address is taken from d. On the same edge, a is loaded with the full 16-bit value (new byte plus the stored byte), valid is set to 1, and the state goes to HOLD.
  - dv=0 -> counter increments.
- Timeout (TIMEOUT>0): in FIRST or SECOND, when the counter reaches TIMEOUT without dv, the state goes to IDLE. err is 1 for exactly one cycle. a is unchanged. The partial tmp contents are discarded.
- HOLD:
  - valid=1, busy=0.
  - ack=1 -> valid cleared. The next state is FIRST if start=1 in the same cycle, otherwise IDLE.
  - start without ack is ignored.
- start asserted while in FIRST or SECOND is ignored; there is no restart mid-capture.
- inc:
  - Applies only in IDLE or HOLD: a <= a + 1, modulo 2^16, so 16'hFFFF -> 16'h0000.
  - Ignored in FIRST and SECOND.
  - inc does not change valid.
  - In HOLD, inc and ack in the same cycle both take effect.
- dv outside FIRST and SECOND is ignored.
- Reset, whether idle or mid-operation:
  - state = IDLE, a = 16'h0000, tmp = 16'h0000, counter = 0.
  - valid = 0, busy = 0, err = 0.
  - Any in-flight capture is discarded.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- start sampled at edge N -> busy=1 after edge N.
- Minimum capture: start at edge N, dv at edges N+1 and N+2 -> a and valid updated after edge N+2. Latency is 3 cycles from start to valid.
- Back-to-back transfers: with ack and start together in HOLD, the next byte can be accepted on the following edge. Sustained rate is one address per 3 cycles.
- Timeout: with dv held low, err rises after the edge where the wait counter hits TIMEOUT, which is TIMEOUT+1 edges after entering the state. busy falls on that same edge.
- Reset is asynchronous on assertion (rst low) and takes effect immediately. Release is sampled on the next rising clk.

## Test plan

- Reset, then start followed by dv bytes 8'h34 then 8'h12, LO_FIRST=1 -> busy for 2 cycles, then a=16'h1234, valid=1 held until ack; valid=0 one cycle after ack.
- LO_FIRST=0, same bytes 8'h34 then 8'h12 -> a=16'h3412.
- TIMEOUT=4: start, one dv byte, then dv low -> err pulses once, state returns to IDLE, a keeps its prior value, valid stays 0.
- In HOLD with a=16'hFFFF, assert inc with ack=0 -> a=16'h0000 and valid stays 1. Then assert ack and start together with next bytes 8'hCD, 8'hAB -> a=16'hABCD with no idle cycle in between.
- Assert rst low between the first and second byte -> a=16'h0000, busy=0, valid=0 immediately. A later dv is ignored until a new start.
- start pulsed during SECOND and dv pulsed in IDLE -> no state change and no a update.

Source files
------------

// File: rtl/adu_assembler.sv
// Byte-to-address assembler: captures two bytes from an 8-bit bus into a 16-bit
// address, presents it with a valid/ack handshake, with per-byte timeout and post-increment.
module adu_assembler #(
    parameter bit          LO_FIRST = 1'b1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic        start,
    input  logic        dv,
    input  logic        ack,
    input  logic        inc,
    output logic [15:0] a,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_HOLD
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
    localparam bit         TO_EN    = (TIMEOUT != 0);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_tmp,   w_tmp_nxt;
    logic [15:0] r_a,     w_a_nxt;
    logic [7:0]  r_cnt,   w_cnt_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err,   w_err_nxt;
    logic        w_expired;

    assign w_expired = TO_EN && (r_cnt == TO_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every target gets a default first; any path that skipped an
        // assignment would otherwise infer a latch.
        w_state_nxt = r_state;
        w_tmp_nxt   = r_tmp;
        w_a_nxt     = r_a;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (inc) w_a_nxt = r_a + 16'd1;
                if (start) begin
                    w_state_nxt = S_FIRST;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_FIRST: begin
                if (dv) begin
                    if (LO_FIRST) w_tmp_nxt[7:0]  = d;
                    else          w_tmp_nxt[15:8] = d;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_SECOND;
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_tmp_nxt   = 16'h0000;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SECOND: begin
                if (dv) begin
                    // The new byte fills whichever half the first byte left empty.
                    w_a_nxt     = LO_FIRST ? {d, r_tmp[7:0]} : {r_tmp[15:8], d};
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_HOLD;
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_tmp_nxt   = 16'h0000;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (inc) w_a_nxt = r_a + 16'd1;
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = start ? S_FIRST : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmp   <= 16'h0000;
            r_a     <= 16'h0000;
            r_cnt   <= 8'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tmp   <= w_tmp_nxt;
            r_a     <= w_a_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign a     = r_a;
    assign valid = r_valid;
    assign busy  = (r_state == S_FIRST) || (r_state == S_SECOND);
    assign err   = r_err;

endmodule
